rggen_irq_coalescer: RTL and testbench

RGGEN_IRQ_COALESCER -- requirements
Module: rggen_irq_coalescer

---
 rtl/rggen_rtl_pkg.sv | 13 +
 rtl/rggen_irq_sat_counter.sv | 24 ++
 rtl/rggen_irq_coalescer.sv | 147 ++++++++++++++
 tb/tb_rggen_irq_coalescer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen RTL library.
// rggen_irq_mode selects how the interrupt coalescer drives its request line.
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_IRQ_LEVEL,
        RGGEN_IRQ_PULSE
    } rggen_irq_mode;

    // Width of the pulse-length counter; covers PULSE_CYCLES up to 255.
    localparam int RGGEN_IRQ_PULSE_COUNT_WIDTH = 8;

endpackage

// File: rtl/rggen_irq_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Holds at all-ones instead of wrapping.
module rggen_irq_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] value
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (increment && (value != '1)) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rggen_irq_coalescer.sv
// Interrupt coalescer: gathers rising edges of enabled status bits and raises
// o_irq once an event-count threshold or a timeout since the first event is reached.
module rggen_irq_coalescer
    import rggen_rtl_pkg::*;
#(
    parameter rggen_irq_mode MODE         = RGGEN_IRQ_LEVEL,
    parameter int            WIDTH        = 1,
    parameter int            COUNT_WIDTH  = 8,
    parameter int            PULSE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       i_status,
    input  logic [WIDTH-1:0]       i_enable,
    input  logic [COUNT_WIDTH-1:0] i_threshold,
    input  logic [COUNT_WIDTH-1:0] i_timeout,
    output logic                   o_irq,
    output logic                   o_pending,
    output logic [COUNT_WIDTH-1:0] o_event_count
);

    localparam int PW = RGGEN_IRQ_PULSE_COUNT_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        COALESCE,
        FIRE,
        HOLD
    } state_e;

    state_e                 state;
    state_e                 next_state;
    logic [WIDTH-1:0]       masked;
    logic [WIDTH-1:0]       masked_q;
    logic                   event_hit;
    logic                   any_masked;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [COUNT_WIDTH-1:0] timer;
    logic [PW-1:0]          pulse_count;
    logic                   pulse_done;
    logic                   count_clear;
    logic                   count_inc;
    logic                   timer_clear;
    logic                   timer_inc;
    logic                   pulse_clear;
    logic                   pulse_inc;
    logic                   irq_d;

    assign masked     = i_status & i_enable;
    assign event_hit  = |(masked & ~masked_q);
    assign any_masked = |masked;
    // Counter value after this cycle's event, used for the threshold compare.
    assign count_next = (event_hit && (count != '1)) ? count + COUNT_WIDTH'(1) : count;
    assign pulse_done = (pulse_count == PW'(PULSE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (event_hit) next_state = COALESCE;
            end
            COALESCE: begin
                // A clear by software beats a fire condition in the same cycle.
                if (!any_masked) begin
                    next_state = IDLE;
                end else if ((count_next >= i_threshold) || (timer == i_timeout)) begin
                    next_state = FIRE;
                end
            end
            FIRE: begin
                if (MODE == RGGEN_IRQ_PULSE) begin
                    if (pulse_done) next_state = HOLD;
                end else if (!any_masked) begin
                    next_state = IDLE;
                end
            end
            HOLD: begin
                if (!any_masked) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        count_clear = (next_state == IDLE);
        count_inc   = event_hit && ((state == IDLE) || (state == COALESCE));
        timer_clear = (next_state == IDLE);
        timer_inc   = (state == COALESCE);
        pulse_clear = (state != FIRE);
        pulse_inc   = (state == FIRE);
        irq_d       = (state == FIRE) && ((MODE == RGGEN_IRQ_PULSE) || any_masked);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            masked_q <= '0;
            o_irq    <= 1'b0;
        end else begin
            masked_q <= masked;
            o_irq    <= irq_d;
        end
    end

    assign o_pending     = |masked_q;
    assign o_event_count = count;

    rggen_irq_sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_event_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (count_clear),
        .increment (count_inc),
        .value     (count)
    );

    rggen_irq_sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clear),
        .increment (timer_inc),
        .value     (timer)
    );

    rggen_irq_sat_counter #(
        .WIDTH (PW)
    ) u_pulse_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pulse_clear),
        .increment (pulse_inc),
        .value     (pulse_count)
    );

endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Bench for rggen_irq_coalescer: level, pulse and 2-bit-counter instances share stimulus;
// a reference model feeds a scoreboard queue and directed checks pin the documented cycle numbers.
module tb_rggen_irq_coalescer;
    import rggen_rtl_pkg::*;

    localparam int PULSE_CYC = 4;
    localparam int S_IDLE = 0, S_COAL = 1, S_FIRE = 2, S_HOLD = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] status;
    logic [2:0] enable;
    logic [7:0] thr8, to8;
    logic [1:0] thr2, to2;

    logic       irq_l, pend_l, irq_p, pend_p, irq_s, pend_s;
    logic [7:0] cnt_l, cnt_p;
    logic [1:0] cnt_s;

    rggen_irq_coalescer #(
        .MODE (RGGEN_IRQ_LEVEL), .WIDTH (3), .COUNT_WIDTH (8), .PULSE_CYCLES (1)
    ) u_dut_lvl (
        .clk (clk), .rst_n (rst_n), .i_status (status), .i_enable (enable),
        .i_threshold (thr8), .i_timeout (to8),
        .o_irq (irq_l), .o_pending (pend_l), .o_event_count (cnt_l)
    );

    rggen_irq_coalescer #(
        .MODE (RGGEN_IRQ_PULSE), .WIDTH (3), .COUNT_WIDTH (8), .PULSE_CYCLES (PULSE_CYC)
    ) u_dut_pls (
        .clk (clk), .rst_n (rst_n), .i_status (status), .i_enable (enable),
        .i_threshold (thr8), .i_timeout (to8),
        .o_irq (irq_p), .o_pending (pend_p), .o_event_count (cnt_p)
    );

    rggen_irq_coalescer #(
        .MODE (RGGEN_IRQ_LEVEL), .WIDTH (3), .COUNT_WIDTH (2), .PULSE_CYCLES (1)
    ) u_dut_sat (
        .clk (clk), .rst_n (rst_n), .i_status (status), .i_enable (enable),
        .i_threshold (thr2), .i_timeout (to2),
        .o_irq (irq_s), .o_pending (pend_s), .o_event_count (cnt_s)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    int n_vec     = 0;
    int n_miscmp  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state, one slot per instance (0 level, 1 pulse, 2 two-bit).
    int         st  [3];
    int         cnt [3];
    int         tmr [3];
    int         pc  [3];
    bit         irq_m [3];
    logic [2:0] mq  [3];
    int         mx  [3] = '{255, 255, 3};
    bit         is_pulse [3] = '{1'b0, 1'b1, 1'b0};

    typedef struct {
        int inst;
        bit irq;
        bit pend;
        int cnt;
    } exp_t;

    exp_t sbq[$];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            st[k] = S_IDLE; cnt[k] = 0; tmr[k] = 0; pc[k] = 0; irq_m[k] = 1'b0; mq[k] = '0;
        end
    endtask

    task automatic go_idle(input int k);
        st[k] = S_IDLE; cnt[k] = 0; tmr[k] = 0; pc[k] = 0;
    endtask

    task automatic model_step(input int k, input logic [2:0] m, input int thr, input int tout);
        bit ev, any, nirq;
        int ncnt;
        ev   = (m & ~mq[k]) != 3'b000;
        any  = (m != 3'b000);
        nirq = (st[k] == S_FIRE) && (is_pulse[k] || any);
        case (st[k])
            S_IDLE: if (ev) begin st[k] = S_COAL; cnt[k] = 1; tmr[k] = 0; end
            S_COAL: begin
                ncnt = ev ? ((cnt[k] + 1 > mx[k]) ? mx[k] : cnt[k] + 1) : cnt[k];
                if (!any) begin
                    go_idle(k);
                end else begin
                    if ((ncnt >= thr) || (tmr[k] == tout)) begin
                        st[k] = S_FIRE; pc[k] = 0;
                    end
                    cnt[k] = ncnt;
                    tmr[k] = (tmr[k] + 1 > mx[k]) ? mx[k] : tmr[k] + 1;
                end
            end
            S_FIRE: begin
                if (is_pulse[k]) begin
                    if (pc[k] == PULSE_CYC - 1) st[k] = S_HOLD;
                    pc[k]++;
                end else if (!any) begin
                    go_idle(k);
                end
            end
            default: if (!any) go_idle(k);
        endcase
        irq_m[k] = nirq;
        mq[k]    = m;
    endtask

    function automatic logic [31:0] dut_irq(input int k);
        case (k)
            0:       return 32'(irq_l);
            1:       return 32'(irq_p);
            default: return 32'(irq_s);
        endcase
    endfunction

    function automatic logic [31:0] dut_pend(input int k);
        case (k)
            0:       return 32'(pend_l);
            1:       return 32'(pend_p);
            default: return 32'(pend_s);
        endcase
    endfunction

    function automatic logic [31:0] dut_cnt(input int k);
        case (k)
            0:       return 32'(cnt_l);
            1:       return 32'(cnt_p);
            default: return 32'(cnt_s);
        endcase
    endfunction

    int cyc;
    int lvl_rise, lvl_fall, lvl_high, pls_high, sat_rises;
    bit sat_prev;

    task automatic mark();
        cyc = 0; lvl_rise = -1; lvl_fall = -1; lvl_high = 0; pls_high = 0; sat_rises = 0;
        sat_prev = irq_s;
    endtask

    // One clock: model predicts post-edge outputs, DUT is sampled on the falling edge.
    task automatic tick();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            model_step(k, status & enable, (k == 2) ? int'(thr2) : int'(thr8),
                       (k == 2) ? int'(to2) : int'(to8));
            e.inst = k; e.irq = irq_m[k]; e.pend = (mq[k] != 3'b000); e.cnt = cnt[k];
            sbq.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check($sformatf("c%0d_i%0d_irq", cyc, e.inst), dut_irq(e.inst), 32'(e.irq));
            check($sformatf("c%0d_i%0d_pending", cyc, e.inst), dut_pend(e.inst), 32'(e.pend));
            check($sformatf("c%0d_i%0d_count", cyc, e.inst), dut_cnt(e.inst), 32'(e.cnt));
        end
        if (irq_l) begin
            lvl_high++;
            if (lvl_rise < 0) lvl_rise = cyc;
        end else if ((lvl_rise >= 0) && (lvl_fall < 0)) begin
            lvl_fall = cyc;
        end
        if (irq_p) pls_high++;
        if (irq_s && !sat_prev) sat_rises++;
        sat_prev = irq_s;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        rst_n = 1'b0; status = '0; enable = 3'b111;
        thr8 = 8'd3; to8 = 8'd255; thr2 = 2'd3; to2 = 2'd3;
        model_reset();
        mark();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_i%0d_irq", k), dut_irq(k), 32'd0);
            check($sformatf("reset_i%0d_pending", k), dut_pend(k), 32'd0);
            check($sformatf("reset_i%0d_count", k), dut_cnt(k), 32'd0);
        end
        #1 rst_n = 1'b1;

        // Threshold 3: events at 10, 20, 30; irq rises at 31, drops when status clears.
        mark();
        run_to(9);  status = 3'b001;
        run_to(19); status = 3'b011;
        run_to(29); status = 3'b111;
        run_to(39); status = 3'b000;
        run_to(45);
        check("thr3_rise_cycle", lvl_rise, 31);
        check("thr3_fall_cycle", lvl_fall, 40);

        // Timeout 5: single event at 10, irq rises at 17.
        thr8 = 8'd200; to8 = 8'd5;
        mark();
        run_to(9);  status = 3'b001;
        run_to(20);
        check("timeout5_rise_cycle", lvl_rise, 17);
        status = 3'b000;
        run_to(23);

        // Pulse mode: exactly four high cycles, silent in HOLD, re-fires after a clear.
        thr8 = 8'd1; to8 = 8'd255;
        mark();
        status = 3'b001;
        run_to(20);
        check("pulse_high_cycles", pls_high, 4);
        check("pulse_hold_low", 32'(irq_p), 0);
        status = 3'b000;
        run_to(23);
        pls_high = 0;
        status = 3'b001;
        run_to(40);
        check("pulse_refire_cycles", pls_high, 4);
        status = 3'b000;
        run_to(43);

        // Two events below threshold 4, then enables dropped: back to idle, no irq.
        thr8 = 8'd4; to8 = 8'd255;
        mark();
        status = 3'b001;
        run_to(4);  status = 3'b011;
        run_to(8);
        check("disable_two_events", 32'(cnt_l), 2);
        enable = 3'b000;
        run_to(9);
        check("disable_count_zero", 32'(cnt_l), 0);
        run_to(12);
        check("disable_no_irq", lvl_high, 0);
        status = 3'b000; enable = 3'b111;
        run_to(14);

        // Two-bit counter with an event every cycle: saturates at 3 and fires once.
        thr8 = 8'd200; to8 = 8'd255; thr2 = 2'd3; to2 = 2'd3;
        mark();
        for (int i = 0; i < 9; i++) begin
            status = 3'(3'b001 << (i % 3));
            tick();
        end
        check("sat_count_held", 32'(cnt_s), 3);
        check("sat_single_fire", sat_rises, 1);
        status = 3'b000;
        repeat (3) tick();
        check("sat_idle_count", 32'(cnt_s), 0);

        // Status cleared on the very cycle the timeout matches: clear wins.
        thr8 = 8'd200; to8 = 8'd3;
        mark();
        status = 3'b001;
        run_to(4);  status = 3'b000;
        run_to(8);
        check("clear_beats_timeout_lvl", lvl_high, 0);
        check("clear_beats_timeout_pls", pls_high, 0);

        // Asynchronous reset while irq is high, then event detection on the first clock.
        thr8 = 8'd1; to8 = 8'd255;
        mark();
        status = 3'b001;
        run_to(4);
        check("areset_precondition", 32'(irq_l), 1);
        #1 rst_n = 1'b0;
        #1;
        check("areset_lvl_irq", 32'(irq_l), 0);
        check("areset_pls_irq", 32'(irq_p), 0);
        check("areset_lvl_count", 32'(cnt_l), 0);
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        mark();
        tick();
        check("release_first_clock_event", 32'(cnt_l), 1);
        run_to(6);
        status = 3'b000;
        run_to(9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
